// File: rtl/intersection_controller_pkg.sv
// Shared types and defaults for the intersection controller (package traffic_pkg).
// Optional build macro: FLASH_MODE_EN adds the FLASH state (7).
package traffic_pkg;

  localparam int unsigned CLK_W          = 8;
  localparam int unsigned PHASE_W        = 3;
  localparam int unsigned GREEN_TIME_DEF  = 60;
  localparam int unsigned YELLOW_TIME_DEF = 5;
  localparam int unsigned ALLRED_TIME_DEF = 2;
  localparam int unsigned PED_SHORT_DEF   = 10;

  typedef enum logic [PHASE_W-1:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    AR_TO_EW  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    AR_TO_NS  = 3'd6
`ifdef FLASH_MODE_EN
    ,
    FLASH     = 3'd7
`endif
  } state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = lamp_t'(3'b100);
  localparam lamp_t LAMP_YELLOW = lamp_t'(3'b010);
  localparam lamp_t LAMP_GREEN  = lamp_t'(3'b001);

endpackage

// File: rtl/intersection_controller_if.sv
// Request inputs and lamp/countdown outputs of the intersection controller.
// Optional build macro: FLASH_MODE_EN adds the flash request.
interface intersection_controller_if;
  import traffic_pkg::*;

  logic               ns_req;
  logic               ew_req;
  logic               ped_req;
`ifdef FLASH_MODE_EN
  logic               flash;
`endif
  logic               ns_red;
  logic               ns_yellow;
  logic               ns_green;
  logic               ew_red;
  logic               ew_yellow;
  logic               ew_green;
  logic [CLK_W-1:0]   clock;
  logic [PHASE_W-1:0] phase;

  modport master (
`ifdef FLASH_MODE_EN
    output flash,
`endif
    output ns_req, ew_req, ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, clock, phase
  );

  modport slave (
`ifdef FLASH_MODE_EN
    input  flash,
`endif
    input  ns_req, ew_req, ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, clock, phase
  );

endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Loadable 8-bit phase down-counter; stops at 1 and flags expiry there.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [CLK_W-1:0] RST_VAL = CLK_W'(ALLRED_TIME_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CLK_W-1:0] load_val,
  input  logic             hold,
  input  logic             dec,
  output logic [CLK_W-1:0] count,
  output logic             expire
);

  logic [CLK_W-1:0] count_d, count_q;

  // Load wins over hold, hold over decrement; never decrement below 1.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (hold) begin
      count_d = count_q;
    end else if (dec && (count_q > CLK_W'(1))) begin
      count_d = count_q - CLK_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == CLK_W'(1));

endmodule

// File: rtl/intersection_controller.sv
// Two-head traffic sequencer: phase FSM, demand latches and registered lamp decode.
// Optional build macro: FLASH_MODE_EN (flash input, FLASH state 7).
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TIME  = GREEN_TIME_DEF,
  parameter int unsigned YELLOW_TIME = YELLOW_TIME_DEF,
  parameter int unsigned ALLRED_TIME = ALLRED_TIME_DEF,
  parameter int unsigned PED_SHORT   = PED_SHORT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  intersection_controller_if.slave  bus
);

  state_e           state_q, state_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  lamp_t            ns_lamp_q, ns_lamp_d;
  lamp_t            ew_lamp_q, ew_lamp_d;
  logic             tmr_load, tmr_hold, tmr_dec, expire;
  logic [CLK_W-1:0] tmr_val, count;
`ifdef FLASH_MODE_EN
  logic             flash_on_q, flash_on_d;
`endif

  // Duration loaded on entry to each phase.
  function automatic logic [CLK_W-1:0] dur(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   dur = CLK_W'(GREEN_TIME);
      NS_YELLOW, EW_YELLOW: dur = CLK_W'(YELLOW_TIME);
      default:              dur = CLK_W'(ALLRED_TIME);
    endcase
  endfunction

  phase_timer #(.RST_VAL(CLK_W'(ALLRED_TIME))) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (tmr_hold),
    .dec      (tmr_dec),
    .count    (count),
    .expire   (expire)
  );

  // Next state, timer control, demand latches and lamp decode of the next state.
  always_comb begin
    state_d   = state_q;
    ns_pend_d = ns_pend_q | bus.ns_req | (bus.ped_req && (state_q == EW_GREEN));
    ew_pend_d = ew_pend_q | bus.ew_req | (bus.ped_req && (state_q == NS_GREEN));
    tmr_load  = 1'b0;
    tmr_val   = count;
    tmr_hold  = 1'b0;
    tmr_dec   = 1'b1;
    ns_lamp_d = LAMP_RED;
    ew_lamp_d = LAMP_RED;
`ifdef FLASH_MODE_EN
    flash_on_d = flash_on_q;
`endif

    case (state_q)
      IDLE:      if (expire) state_d = NS_GREEN;
      NS_YELLOW: if (expire) state_d = AR_TO_EW;
      AR_TO_EW:  if (expire) state_d = EW_GREEN;
      EW_YELLOW: if (expire) state_d = AR_TO_NS;
      AR_TO_NS:  if (expire) state_d = NS_GREEN;
      NS_GREEN, EW_GREEN: begin
        if (expire) begin
          if ((state_q == NS_GREEN) ? ew_pend_q : ns_pend_q) begin
            state_d = (state_q == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
          end else begin
            tmr_hold = 1'b1;
          end
        end else if (bus.ped_req && (count > CLK_W'(PED_SHORT))) begin
          tmr_load = 1'b1;
          tmr_val  = CLK_W'(PED_SHORT);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      tmr_val  = dur(state_d);
    end

`ifdef FLASH_MODE_EN
    // Flash overrides every transition; yellows toggle each YELLOW_TIME cycles.
    if (bus.flash) begin
      state_d  = FLASH;
      tmr_hold = 1'b0;
      tmr_load = 1'b0;
      if (state_q != FLASH) begin
        tmr_load   = 1'b1;
        tmr_val    = CLK_W'(YELLOW_TIME);
        flash_on_d = 1'b1;
      end else if (expire) begin
        tmr_load   = 1'b1;
        tmr_val    = CLK_W'(YELLOW_TIME);
        flash_on_d = ~flash_on_q;
      end
    end else if (state_q == FLASH) begin
      state_d   = IDLE;
      tmr_load  = 1'b1;
      tmr_val   = CLK_W'(ALLRED_TIME);
      ns_pend_d = 1'b0;
      ew_pend_d = 1'b0;
    end
`endif

    // Entering a green serves that road's request, so its clear beats a same-cycle set.
    if ((state_d == NS_GREEN) && (state_q != NS_GREEN)) ns_pend_d = 1'b0;
    if ((state_d == EW_GREEN) && (state_q != EW_GREEN)) ew_pend_d = 1'b0;

    case (state_d)
      NS_GREEN:  ns_lamp_d = LAMP_GREEN;
      NS_YELLOW: ns_lamp_d = LAMP_YELLOW;
      EW_GREEN:  ew_lamp_d = LAMP_GREEN;
      EW_YELLOW: ew_lamp_d = LAMP_YELLOW;
`ifdef FLASH_MODE_EN
      FLASH: begin
        ns_lamp_d = lamp_t'({1'b0, flash_on_d, 1'b0});
        ew_lamp_d = lamp_t'({1'b0, flash_on_d, 1'b0});
      end
`endif
      default: ;
    endcase
  end

  // State, demand and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ns_lamp_q  <= LAMP_RED;
      ew_lamp_q  <= LAMP_RED;
`ifdef FLASH_MODE_EN
      flash_on_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ns_lamp_q  <= ns_lamp_d;
      ew_lamp_q  <= ew_lamp_d;
`ifdef FLASH_MODE_EN
      flash_on_q <= flash_on_d;
`endif
    end
  end

  assign bus.ns_red    = ns_lamp_q.red;
  assign bus.ns_yellow = ns_lamp_q.yellow;
  assign bus.ns_green  = ns_lamp_q.green;
  assign bus.ew_red    = ew_lamp_q.red;
  assign bus.ew_yellow = ew_lamp_q.yellow;
  assign bus.ew_green  = ew_lamp_q.green;
  assign bus.clock     = count;
  assign bus.phase     = PHASE_W'(state_q);

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller (FLASH_MODE_EN optional).
module tb_intersection_controller;

  localparam int unsigned G  = 60;
  localparam int unsigned Y  = 5;
  localparam int unsigned AR = 2;
  localparam int unsigned PS = 10;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] ck;
    logic [5:0] lamps;   // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    logic       nsp;
    logic       ewp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  // reference model state
  logic [2:0] m_state;
  logic [7:0] m_clock;
  logic       m_nsp, m_ewp, m_fon;

  intersection_controller_if bus();

  intersection_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_dur(input logic [2:0] s);
    if (s == 3'd1 || s == 3'd4) return 8'(G);
    if (s == 3'd2 || s == 3'd5) return 8'(Y);
    return 8'(AR);
  endfunction

  function automatic logic [5:0] m_lamps(input logic [2:0] s, input logic fon);
    logic [2:0] ns, ew;
    ns = 3'b100;
    ew = 3'b100;
    if (s == 3'd1) ns = 3'b001;
    if (s == 3'd2) ns = 3'b010;
    if (s == 3'd4) ew = 3'b001;
    if (s == 3'd5) ew = 3'b010;
    if (s == 3'd7) begin
      ns = {1'b0, fon, 1'b0};
      ew = {1'b0, fon, 1'b0};
    end
    return {ns, ew};
  endfunction

  task automatic model_reset();
    m_state = 3'd0;
    m_clock = 8'(AR);
    m_nsp   = 1'b0;
    m_ewp   = 1'b0;
    m_fon   = 1'b0;
  endtask

  // Advance the model one edge from the current inputs and queue the expectation.
  task automatic step();
    logic [2:0] s, n;
    logic [7:0] c;
    logic nsp, ewp, fon;
    exp_t e;
    s   = m_state;
    n   = s;
    fon = m_fon;
    c   = m_clock - 8'd1;
    nsp = m_nsp | bus.ns_req | (bus.ped_req && s == 3'd4);
    ewp = m_ewp | bus.ew_req | (bus.ped_req && s == 3'd1);
    if (s == 3'd1 || s == 3'd4) begin
      if (m_clock == 8'd1) begin
        if ((s == 3'd1 && m_ewp) || (s == 3'd4 && m_nsp)) begin
          n = s + 3'd1;
          c = 8'(Y);
        end else begin
          c = 8'd1;
        end
      end else if (bus.ped_req && m_clock > 8'(PS)) begin
        c = 8'(PS);
      end
    end else if (m_clock == 8'd1) begin
      n = (s == 3'd6) ? 3'd1 : s + 3'd1;
      c = m_dur(n);
    end
`ifdef FLASH_MODE_EN
    if (bus.flash) begin
      n = 3'd7;
      if (s != 3'd7) begin
        c = 8'(Y);
        fon = 1'b1;
      end else if (m_clock == 8'd1) begin
        c = 8'(Y);
        fon = ~m_fon;
      end else begin
        c = m_clock - 8'd1;
      end
    end else if (s == 3'd7) begin
      n = 3'd0;
      c = 8'(AR);
      nsp = 1'b0;
      ewp = 1'b0;
    end
`endif
    if (n == 3'd1 && s != 3'd1) nsp = 1'b0;
    if (n == 3'd4 && s != 3'd4) ewp = 1'b0;
    m_state = n;
    m_clock = c;
    m_nsp   = nsp;
    m_ewp   = ewp;
    m_fon   = fon;
    e.ph    = n;
    e.ck    = c;
    e.lamps = m_lamps(n, fon);
    e.nsp   = nsp;
    e.ewp   = ewp;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard: compare DUT against the oldest queued expectation after each edge.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] act;
    if (rst_n && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green};
      tests_run++;
      if (bus.phase !== e.ph || bus.clock !== e.ck || act !== e.lamps ||
          dut.ns_pend_q !== e.nsp || dut.ew_pend_q !== e.ewp ||
          (bus.ns_green === 1'b1 && bus.ew_green === 1'b1)) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t got ph=%0d ck=%0d lamps=%b nsp=%b ewp=%b, want ph=%0d ck=%0d lamps=%b nsp=%b ewp=%b",
                 $time, bus.phase, bus.clock, act, dut.ns_pend_q, dut.ew_pend_q,
                 e.ph, e.ck, e.lamps, e.nsp, e.ewp);
      end
    end
  end

  task automatic clear_inputs();
    bus.ns_req  = 1'b0;
    bus.ew_req  = 1'b0;
    bus.ped_req = 1'b0;
`ifdef FLASH_MODE_EN
    bus.flash   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] act;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    act = {bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green};
    tests_run++;
    if (bus.phase !== 3'd0 || bus.clock !== 8'(AR) || act !== 6'b100100 ||
        dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values got ph=%0d ck=%0d lamps=%b, want ph=0 ck=%0d lamps=100100", bus.phase, bus.clock, act, AR);
    end
    do_reset();
  endtask

  task automatic test_normal_cycle();
    logic [2:0] want_ph[8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    logic [7:0] want_ck[8] = '{8'd60, 8'd1, 8'd5, 8'd2, 8'd60, 8'd5, 8'd2, 8'd60};
    int         len[8]     = '{2, 59, 1, 5, 2, 60, 5, 2};
    do_reset();
    bus.ns_req = 1'b1;
    bus.ew_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      steps(len[k]);
      tests_run++;
      if (bus.phase !== want_ph[k] || bus.clock !== want_ck[k]) begin
        tests_failed++;
        $display("FAIL normal_cycle_%0d got ph=%0d ck=%0d, want ph=%0d ck=%0d", k, bus.phase, bus.clock, want_ph[k], want_ck[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_ped();
    do_reset();
    steps(22);
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    tests_run++;
    if (bus.clock !== 8'(PS) || dut.ew_pend_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL ped_shorten got ck=%0d ewp=%b, want ck=%0d ewp=1", bus.clock, dut.ew_pend_q, PS);
    end
    steps(2);
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    tests_run++;
    if (bus.clock !== 8'd7) begin
      tests_failed++;
      $display("FAIL ped_no_reload got ck=%0d, want 7", bus.clock);
    end
    steps(7);
    tests_run++;
    if (bus.phase !== 3'd2 || bus.clock !== 8'(Y)) begin
      tests_failed++;
      $display("FAIL ped_to_yellow got ph=%0d ck=%0d, want ph=2 ck=%0d", bus.phase, bus.clock, Y);
    end
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    tests_run++;
    if (dut.ns_pend_q !== 1'b0 || bus.clock !== 8'd4) begin
      tests_failed++;
      $display("FAIL ped_in_yellow got nsp=%b ck=%0d, want nsp=0 ck=4", dut.ns_pend_q, bus.clock);
    end
  endtask

  task automatic test_hold();
    int bad;
    do_reset();
    steps(61);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.phase !== 3'd1 || bus.clock !== 8'd1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL green_hold got %0d cycles off-hold, want 0", bad);
    end
    bus.ew_req = 1'b1;
    step();
    bus.ew_req = 1'b0;
    tests_run++;
    if (bus.phase !== 3'd1 || bus.clock !== 8'd1) begin
      tests_failed++;
      $display("FAIL hold_demand_latch got ph=%0d ck=%0d, want ph=1 ck=1", bus.phase, bus.clock);
    end
    step();
    tests_run++;
    if (bus.phase !== 3'd2 || bus.clock !== 8'(Y)) begin
      tests_failed++;
      $display("FAIL hold_release got ph=%0d ck=%0d, want ph=2 ck=%0d", bus.phase, bus.clock, Y);
    end
  endtask

  task automatic test_entry_clear();
    do_reset();
    step();
    bus.ns_req = 1'b1;
    step();
    bus.ns_req = 1'b0;
    tests_run++;
    if (bus.phase !== 3'd1 || dut.ns_pend_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL entry_clear got ph=%0d nsp=%b, want ph=1 nsp=0", bus.phase, dut.ns_pend_q);
    end
    bus.ns_req = 1'b1;
    step();
    bus.ns_req = 1'b0;
    tests_run++;
    if (dut.ns_pend_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL entry_then_set got nsp=%b, want 1", dut.ns_pend_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] act;
    do_reset();
    bus.ns_req = 1'b1;
    bus.ew_req = 1'b1;
    steps(99);
    tests_run++;
    if (bus.phase !== 3'd4 || bus.clock !== 8'd30) begin
      tests_failed++;
      $display("FAIL reach_ew30 got ph=%0d ck=%0d, want ph=4 ck=30", bus.phase, bus.clock);
    end
    rst_n = 1'b0;
    #1;
    act = {bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green};
    tests_run++;
    if (bus.phase !== 3'd0 || bus.clock !== 8'(AR) || act !== 6'b100100 ||
        dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got ph=%0d ck=%0d lamps=%b, want ph=0 ck=%0d lamps=100100", bus.phase, bus.clock, act, AR);
    end
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    steps(2);
    tests_run++;
    if (bus.phase !== 3'd1 || bus.clock !== 8'(G)) begin
      tests_failed++;
      $display("FAIL after_reset got ph=%0d ck=%0d, want ph=1 ck=%0d", bus.phase, bus.clock, G);
    end
  endtask

`ifdef FLASH_MODE_EN
  task automatic test_flash();
    logic want_y[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int   len[4]    = '{1, 4, 1, 4};
    do_reset();
    bus.ns_req = 1'b1;
    bus.ew_req = 1'b1;
    steps(80);
    bus.flash = 1'b1;
    for (int k = 0; k < 4; k++) begin
      steps(len[k]);
      tests_run++;
      if (bus.phase !== 3'd7 || bus.ns_yellow !== want_y[k] || bus.ew_yellow !== want_y[k] ||
          bus.ns_red !== 1'b0 || bus.ew_red !== 1'b0) begin
        tests_failed++;
        $display("FAIL flash_%0d got ph=%0d ny=%b ey=%b nr=%b er=%b, want ph=7 y=%b r=0",
                 k, bus.phase, bus.ns_yellow, bus.ew_yellow, bus.ns_red, bus.ew_red, want_y[k]);
      end
    end
    clear_inputs();
    step();
    tests_run++;
    if (bus.phase !== 3'd0 || bus.clock !== 8'(AR) || bus.ns_red !== 1'b1 || bus.ew_red !== 1'b1 ||
        dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL flash_exit got ph=%0d ck=%0d nr=%b er=%b, want ph=0 ck=%0d both red", bus.phase, bus.clock, bus.ns_red, bus.ew_red, AR);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_normal_cycle();
    test_ped();
    test_hold();
    test_entry_clear();
    test_reset_mid();
`ifdef FLASH_MODE_EN
    test_flash();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
